mop_sequencer: RTL and testbench
================================

MOP_SEQUENCER -- requirements
Module: mop_sequencer

Interface
REQ-001 SHALL have parameter BRAM_DEPTH, default 10: width of each expanded micro-op address.
REQ-002 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have in_valid, input, 1: an instruction is presented.
REQ-005 SHALL have in_inst, input, 36 (CONTROL::instruction_t): opcode[35:21] {field[2], t, arith[4], me, cm[3], end_mop_cnt[4]}, dst[20:14], src0[13:7], src1[6:0].
REQ-006 SHALL have in_ready, output, 1: the instruction is accepted when in_valid && in_ready.
REQ-007 SHALL have out_valid, output, 1: out_mop holds a valid micro-op.
REQ-008 SHALL have out_mop, output, 19+3*BRAM_DEPTH (CONTROL::micro_ops_t): {csig, dst, src0, src1}.
REQ-009 SHALL have out_ready, input, 1: the micro-op is consumed when out_valid && out_ready.
REQ-010 SHALL have busy, output, 1: high while state is not IDLE.
REQ-011 SHALL have out_last, output, 1: high with the final micro-op of an instruction.

Function
REQ-012 SHALL have an FSM with states IDLE and ISSUE.
REQ-013 SHALL assert in_ready only in IDLE (in_ready = ~busy).
REQ-014 SHALL, on acceptance, capture in_inst, clear the 4-bit index i to 0, enter ISSUE and assert out_valid in the next cycle.
REQ-015 SHALL expand one instruction into end_mop_cnt+1 micro-ops (1..16), with indices i = 0..end_mop_cnt in order.
REQ-016 SHALL generate addresses for micro-op i as zero-extended 7-bit operand + i, modulo 2^BRAM_DEPTH, for dst, src0 and src1 independently (wrap 10'h3FF+1 -> 0).
REQ-017 SHALL map csig as follows: cm = sub_op.cm; me0 = me1 = sub_op.me; pm = field; pos = {t, arith[3]}; pom1 = pom2 = pom3 = arith[2:0]; inve = (arith == 4'hF).
REQ-018 SHALL drive out_mop and out_last from registers, with no combinational path from in_* to out_*.
REQ-019 SHALL hold out_mop, out_valid and out_last stable while out_valid && !out_ready (stall), and SHALL NOT drop or duplicate any micro-op.
REQ-020 SHALL, on each handshake with i < end_mop_cnt, increment i and present the next micro-op in the next cycle, with no bubble.
REQ-021 SHALL, on the handshake where i == end_mop_cnt, return to IDLE and deassert out_valid, busy and out_last in the next cycle.
REQ-022 SHALL accept at most one new instruction per cycle; the earliest new acceptance is the cycle after the last micro-op handshake, giving a 1-cycle bubble per instruction.
REQ-023 SHALL ignore in_inst when in_valid is low, and SHALL ignore in_valid while busy.

Reset
REQ-024 SHALL, on rst_n low, immediately set state = IDLE, i = 0, out_valid = 0, out_last = 0, busy = 0, out_mop = 0, in_ready = 1 (after reset release).
REQ-025 SHALL abandon any partially issued instruction on reset mid-ISSUE, with no further micro-ops issued for it after release.

Configuration
REQ-026 SHALL, when macro MOPSEQ_PERF_CNT_EN is defined, add output perf_mops[31:0]: the count of micro-op handshakes, reset to 0, wrapping at 2^32.
REQ-027 SHALL, when MOPSEQ_PERF_CNT_EN is undefined, have no perf_mops port and no counter logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover single op: end_mop_cnt=0, dst=5, src0=7, src1=9, out_ready=1 -> one micro-op {dst=5, src0=7, src1=9}, out_last=1, busy for exactly 1 cycle after acceptance.
REQ-029 SHALL cover burst: end_mop_cnt=3, dst=0x10, src0=0x20, src1=0x30 -> 4 back-to-back micro-ops, dst 0x10..0x13, src0 0x20..0x23, src1 0x30..0x33, out_last only on the 4th.
REQ-030 SHALL cover backpressure: end_mop_cnt=2 with out_ready low for 3 cycles on the 2nd micro-op -> that micro-op held unchanged, 3 micro-ops total, in_ready low throughout.
REQ-031 SHALL cover decode: arith=4'hF, t=1, field=2, cm=5, me=1 -> inve=1, pos=2'b11, pom1..3=3'b111, pm=2, cm=5, me0=me1=1.
REQ-032 SHALL cover reset mid-op: end_mop_cnt=15, rst_n pulsed low after the 6th handshake -> out_valid=0 immediately, no further micro-ops, in_ready=1 after release.
REQ-033 SHALL cover perf counter: with MOPSEQ_PERF_CNT_EN, instructions with end_mop_cnt 3, 0 and 15 -> perf_mops=21; without the macro, the same stream compiles and produces identical out_mop.

Source files
------------

// File: rtl/mop_sequencer.sv
// Expands one 36-bit instruction into 1..16 micro-ops with per-index address offsets.
// Optional handshake counter output perf_mops is enabled by defining MOPSEQ_PERF_CNT_EN.
module mop_sequencer #(
  parameter int BRAM_DEPTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [35:0]                  in_inst,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [19+3*BRAM_DEPTH-1:0]   out_mop,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         out_last
`ifdef MOPSEQ_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_mops
`endif
);

  localparam int MOP_W = 19 + 3*BRAM_DEPTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [35:0]      inst_p0;
  logic [3:0]       idx_p0, idx_nxt;
  logic [MOP_W-1:0] mop_p1, mop_nxt;
  logic             last_p1, last_nxt;
  logic             load_inst;

  function automatic logic [BRAM_DEPTH-1:0] gen_addr(input logic [6:0] op,
                                                     input logic [3:0] idx);
    gen_addr = BRAM_DEPTH'(op) + BRAM_DEPTH'(idx);
  endfunction

  // dec = opcode without end_mop_cnt: {field[2], t, arith[4], me, cm[3]}.
  // csig layout (MSB first): cm[3], me0, me1, pm[2], pos[2], pom1[3], pom2[3], pom3[3], inve.
  function automatic logic [18:0] gen_csig(input logic [10:0] dec);
    logic [1:0] field;
    logic       t;
    logic [3:0] arith;
    logic       me;
    logic [2:0] cm;
    {field, t, arith, me, cm} = dec;
    gen_csig = {cm, me, me, field, t, arith[3], arith[2:0], arith[2:0], arith[2:0],
                (arith == 4'hF)};
  endfunction

  function automatic logic [MOP_W-1:0] gen_mop(input logic [10:0] dec,
                                               input logic [6:0]  dst,
                                               input logic [6:0]  src0,
                                               input logic [6:0]  src1,
                                               input logic [3:0]  idx);
    gen_mop = {gen_csig(dec), gen_addr(dst, idx), gen_addr(src0, idx), gen_addr(src1, idx)};
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_p0;
    mop_nxt   = mop_p1;
    last_nxt  = last_p1;
    load_inst = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = ISSUE;
          idx_nxt   = 4'd0;
          load_inst = 1'b1;
          mop_nxt   = gen_mop(in_inst[35:25], in_inst[20:14], in_inst[13:7], in_inst[6:0], 4'd0);
          last_nxt  = (in_inst[24:21] == 4'd0);
        end
      end
      ISSUE: begin
        if (out_ready) begin
          if (idx_p0 == inst_p0[24:21]) begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
            last_nxt  = 1'b0;
          end else begin
            idx_nxt  = idx_p0 + 4'd1;
            mop_nxt  = gen_mop(inst_p0[35:25], inst_p0[20:14], inst_p0[13:7], inst_p0[6:0],
                               idx_p0 + 4'd1);
            last_nxt = ((idx_p0 + 4'd1) == inst_p0[24:21]);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: captured instruction and index; p1: registered micro-op presented downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx_p0  <= 4'd0;
      inst_p0 <= '0;
      mop_p1  <= '0;
      last_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx_p0  <= idx_nxt;
      mop_p1  <= mop_nxt;
      last_p1 <= last_nxt;
      if (load_inst) inst_p0 <= in_inst;
    end
  end

  assign busy      = (state != IDLE);
  assign in_ready  = ~busy;
  assign out_valid = (state == ISSUE);
  assign out_mop   = mop_p1;
  assign out_last  = last_p1;

`ifdef MOPSEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       perf_mops <= 32'd0;
    else if (out_valid && out_ready)  perf_mops <= perf_mops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mop_sequencer.sv
// Directed bench for mop_sequencer: reset, single op, burst, stall, decode, back-to-back,
// reset mid-instruction and (with MOPSEQ_PERF_CNT_EN) the handshake counter.
module tb_mop_sequencer;
  localparam int BD    = 10;
  localparam int MOP_W = 19 + 3*BD;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [35:0]      in_inst;
  logic             in_ready;
  logic             out_valid;
  logic [MOP_W-1:0] out_mop;
  logic             out_ready;
  logic             busy;
  logic             out_last;
`ifdef MOPSEQ_PERF_CNT_EN
  logic [31:0]      perf_mops;
`endif

  int checks = 0;
  int errors = 0;

  mop_sequencer #(.BRAM_DEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_mop(out_mop), .out_ready(out_ready), .busy(busy),
    .out_last(out_last)
`ifdef MOPSEQ_PERF_CNT_EN
    , .perf_mops(perf_mops)
`endif
  );

  always #5 clk = ~clk;

  wire [18:0]   f_csig = out_mop[MOP_W-1:3*BD];
  wire [BD-1:0] f_dst  = out_mop[3*BD-1:2*BD];
  wire [BD-1:0] f_src0 = out_mop[2*BD-1:BD];
  wire [BD-1:0] f_src1 = out_mop[BD-1:0];

  function automatic logic [35:0] mk_inst(input logic [1:0] field, input logic t,
                                          input logic [3:0] arith, input logic me,
                                          input logic [2:0] cm, input logic [3:0] endc,
                                          input logic [6:0] d, input logic [6:0] s0,
                                          input logic [6:0] s1);
    mk_inst = {field, t, arith, me, cm, endc, d, s0, s1};
  endfunction

  // Present an instruction for one edge; returns at acceptance edge + 1.
  task automatic send(input logic [35:0] inst);
    in_inst  = inst;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_mop !== '0) begin errors++; $display("FAIL reset_out_mop got %h exp 0", out_mop); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
`ifdef MOPSEQ_PERF_CNT_EN
    checks++; if (perf_mops !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d exp 0", perf_mops); end
`endif
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    send(mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 7'd5, 7'd7, 7'd9));
    checks++; if ({out_valid, busy, in_ready, out_last} !== 4'b1101) begin errors++; $display("FAIL single_ctrl got %b exp 1101", {out_valid, busy, in_ready, out_last}); end
    checks++; if ({f_dst, f_src0, f_src1} !== {10'd5, 10'd7, 10'd9}) begin errors++; $display("FAIL single_addr got %h/%h/%h exp 5/7/9", f_dst, f_src0, f_src1); end
    checks++; if (f_csig !== 19'd0) begin errors++; $display("FAIL single_csig got %h exp 0", f_csig); end
    @(posedge clk); #1;
    checks++; if ({out_valid, busy, in_ready, out_last} !== 4'b0010) begin errors++; $display("FAIL single_done got %b exp 0010", {out_valid, busy, in_ready, out_last}); end
  endtask

  task automatic test_burst;
    out_ready = 1'b1;
    send(mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd3, 7'h10, 7'h20, 7'h30));
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL burst_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if ({f_dst, f_src0, f_src1} !== {10'(16'h10 + k), 10'(16'h20 + k), 10'(16'h30 + k)}) begin errors++; $display("FAIL burst_addr[%0d] got %h/%h/%h", k, f_dst, f_src0, f_src1); end
      checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL burst_last[%0d] got %b exp %b", k, out_last, (k == 3)); end
      @(posedge clk); #1;
    end
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL burst_end got %b exp 00", {out_valid, busy}); end
  endtask

  task automatic test_backpressure;
    int ops;
    ops = 0;
    out_ready = 1'b1;
    send(mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd2, 7'h01, 7'h02, 7'h03));
    checks++; if (f_dst !== 10'h01) begin errors++; $display("FAIL bp_op0 got %h exp 001", f_dst); end
    ops++;
    @(posedge clk); #1;
    checks++; if ({f_dst, f_src0, f_src1, out_last} !== {10'h02, 10'h03, 10'h04, 1'b0}) begin errors++; $display("FAIL bp_op1 got %h/%h/%h last %b", f_dst, f_src0, f_src1, out_last); end
    ops++;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = mk_inst(2'd3, 1'b1, 4'hF, 1'b1, 3'd7, 4'd9, 7'h55, 7'h66, 7'h77);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready, out_last} !== 3'b100) begin errors++; $display("FAIL bp_stall_ctrl[%0d] got %b exp 100", k, {out_valid, in_ready, out_last}); end
      checks++; if (out_mop !== {19'd0, 10'h02, 10'h03, 10'h04}) begin errors++; $display("FAIL bp_stall_hold[%0d] got %h", k, out_mop); end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    checks++; if ({out_valid, out_last, f_dst, f_src0, f_src1} !== {2'b11, 10'h03, 10'h04, 10'h05}) begin errors++; $display("FAIL bp_op2 got v%b l%b %h/%h/%h", out_valid, out_last, f_dst, f_src0, f_src1); end
    ops++;
    @(posedge clk); #1;
    checks++; if ({out_valid, busy, ops} !== {2'b00, 32'd3}) begin errors++; $display("FAIL bp_end got v%b b%b ops %0d exp 00/3", out_valid, busy, ops); end
  endtask

  task automatic test_decode;
    out_ready = 1'b1;
    send(mk_inst(2'd2, 1'b1, 4'hF, 1'b1, 3'd5, 4'd1, 7'h7F, 7'h7E, 7'h00));
    for (int k = 0; k < 2; k++) begin
      checks++; if (f_csig !== 19'b101_1_1_10_11_111_111_111_1) begin errors++; $display("FAIL decode_csig[%0d] got %b", k, f_csig); end
      checks++; if ({f_dst, f_src0, f_src1} !== {10'(16'h7F + k), 10'(16'h7E + k), 10'(k)}) begin errors++; $display("FAIL decode_addr[%0d] got %h/%h/%h", k, f_dst, f_src0, f_src1); end
      @(posedge clk); #1;
    end
    send(mk_inst(2'd1, 1'b0, 4'h7, 1'b0, 3'd2, 4'd0, 7'h00, 7'h00, 7'h00));
    checks++; if (f_csig !== 19'b010_0_0_01_00_111_111_111_0) begin errors++; $display("FAIL decode_csig2 got %b", f_csig); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    in_inst  = mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd1, 7'h08, 7'h09, 7'h0A);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_inst = mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd0, 7'h40, 7'h41, 7'h42);
    checks++; if ({out_valid, f_dst, out_last} !== {1'b1, 10'h08, 1'b0}) begin errors++; $display("FAIL b2b_a0 got v%b %h l%b", out_valid, f_dst, out_last); end
    @(posedge clk); #1;
    checks++; if ({out_valid, f_dst, out_last} !== {1'b1, 10'h09, 1'b1}) begin errors++; $display("FAIL b2b_a1 got v%b %h l%b", out_valid, f_dst, out_last); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL b2b_bubble got %b exp 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, f_dst, f_src1, out_last} !== {1'b1, 10'h40, 10'h42, 1'b1}) begin errors++; $display("FAIL b2b_b0 got v%b %h %h l%b", out_valid, f_dst, f_src1, out_last); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    send(mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 4'd15, 7'h40, 7'h50, 7'h60));
    for (int k = 0; k < 6; k++) begin
      checks++; if (f_dst !== 10'(16'h40 + k)) begin errors++; $display("FAIL rmid_op[%0d] got %h", k, f_dst); end
      @(posedge clk); #1;
    end
    checks++; if ({out_valid, f_dst} !== {1'b1, 10'h46}) begin errors++; $display("FAIL rmid_op6 got v%b %h exp 1/046", out_valid, f_dst); end
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, busy, out_last} !== 3'b000) begin errors++; $display("FAIL rmid_async got %b exp 000", {out_valid, busy, out_last}); end
    checks++; if (out_mop !== '0) begin errors++; $display("FAIL rmid_mop got %h exp 0", out_mop); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL rmid_after[%0d] got %b exp 01", k, {out_valid, in_ready}); end
    end
`ifdef MOPSEQ_PERF_CNT_EN
    checks++; if (perf_mops !== 32'd0) begin errors++; $display("FAIL rmid_perf got %0d exp 0", perf_mops); end
`endif
  endtask

  task automatic test_perf;
    logic [3:0] ends [3];
    ends = '{4'd3, 4'd0, 4'd15};
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      send(mk_inst(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, ends[n], 7'h70, 7'h00, 7'h11));
      for (int k = 0; k <= int'(ends[n]); k++) begin
        checks++; if ({out_valid, f_dst, f_src1} !== {1'b1, 10'(16'h70 + k), 10'(16'h11 + k)}) begin errors++; $display("FAIL perf_stream[%0d][%0d] got v%b %h %h", n, k, out_valid, f_dst, f_src1); end
        @(posedge clk); #1;
      end
    end
`ifdef MOPSEQ_PERF_CNT_EN
    checks++; if (perf_mops !== 32'd21) begin errors++; $display("FAIL perf_count got %0d exp 21", perf_mops); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
